// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding
// and default sizing parameters.
package bus_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ       = 4;
  localparam int DEFAULT_GRANT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter-facing bundle: master requests/grants plus the monitored shared-bus
// strobes. The arbiter uses the slave view; the bus/master side uses master.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] request;
  logic [NUM_REQ-1:0] granted;
  logic               begin_transaction;
  logic               end_transaction;
  logic               error;
  logic [ID_W-1:0]    active_id;
  logic               bus_idle;

  modport slave (
    input  request, begin_transaction, end_transaction, error,
    output granted, active_id, bus_idle
  );

  modport master (
    output request, begin_transaction, end_transaction, error,
    input  granted, active_id, bus_idle
  );

endinterface

// File: rtl/bus_arbiter_rr_priority_select.sv
// Combinational round-robin picker: the first set request bit found when
// scanning upward from (pointer+1) mod NUM_REQ, wrapping around.
module rr_priority_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         request,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate to the nearest so the nearest set bit
  // is the last one assigned and therefore wins, with no early exit needed.
  always_comb begin
    // NOTE: every output and temporary gets a default first so no path
    // through the loop leaves a value held, which would infer a latch.
    valid  = 1'b0;
    winner = pointer;
    idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(pointer) + i) % NUM_REQ);
      if (request[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter: IDLE -> GRANT -> BUSY -> RELEASE with a
// grant timeout, a registered one-hot grant and a round-robin owner pointer.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT
) (
  input  logic          system_clock,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int                ID_W     = $clog2(NUM_REQ);
  localparam int                CNT_W    = $clog2(GRANT_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ID_W-1:0]   ID_RESET = ID_W'(NUM_REQ - 1);

  state_e             state, state_nxt;
  logic [NUM_REQ-1:0] granted_q, granted_nxt;
  logic [ID_W-1:0]    active_id_q, active_id_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_id;
  logic               owner_req;

  rr_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
    .request (bus.request),
    .pointer (active_id_q),
    .valid   (sel_valid),
    .winner  (sel_id)
  );

  assign owner_req = bus.request[active_id_q];

  always_comb begin
    state_nxt     = state;
    granted_nxt   = granted_q;
    active_id_nxt = active_id_q;
    wait_cnt_nxt  = wait_cnt;
    unique case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_nxt     = ST_GRANT;
          granted_nxt   = NUM_REQ'(1) << sel_id;
          active_id_nxt = sel_id;
          wait_cnt_nxt  = '0;
        end
      end
      ST_GRANT: begin
        // A begin coinciding with end is a complete one-cycle transaction.
        if (bus.error || (bus.begin_transaction && bus.end_transaction)) begin
          state_nxt   = ST_RELEASE;
          granted_nxt = '0;
        end else if (bus.begin_transaction) begin
          state_nxt = ST_BUSY;
        end else if (!owner_req || wait_cnt == CNT_LAST) begin
          state_nxt   = ST_RELEASE;
          granted_nxt = '0;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (bus.end_transaction || bus.error) begin
          state_nxt   = ST_RELEASE;
          granted_nxt = '0;
        end
      end
      ST_RELEASE: begin
        state_nxt   = ST_IDLE;
        granted_nxt = '0;
      end
      default: begin
        state_nxt   = ST_IDLE;
        granted_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge system_clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= ST_IDLE;
      granted_q   <= '0;
      active_id_q <= ID_RESET;
      wait_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      granted_q   <= granted_nxt;
      active_id_q <= active_id_nxt;
      wait_cnt    <= wait_cnt_nxt;
    end
  end

  assign bus.granted   = granted_q;
  assign bus.active_id = active_id_q;
  assign bus.bus_idle  = (state == ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// rotation/timeout sequences, then random traffic against a reference model.
module tb_bus_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic system_clock = 1'b0;
  logic reset;

  bus_arbiter_if #(.NUM_REQ(N)) bus ();

  bus_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(T)) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 system_clock = ~system_clock;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       beg;
    logic       fin;
    logic       err;
    logic [3:0] g;
    logic [1:0] id;
    logic       idle;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner index (-1 = none), release-cycle flag, cycles
  // spent waiting for begin, transaction-in-progress flag, last owner.
  int m_owner, m_rel, m_wait, m_tx, m_last;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] req,
                       input logic b, input logic f, input logic e);
    reset                 = r;
    bus.request           = req;
    bus.begin_transaction = b;
    bus.end_transaction   = f;
    bus.error             = e;
    @(posedge system_clock);
    #1;
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic beg,
                     input logic fin, input logic err, input logic [3:0] g,
                     input logic [1:0] id, input logic idle);
    vec_t v;
    v.rst = rst; v.req = req; v.beg = beg; v.fin = fin; v.err = err;
    v.g = g; v.id = id; v.idle = idle;
    vecs.push_back(v);
  endtask

  task automatic model_step(input logic r, input logic [3:0] req,
                            input logic b, input logic f, input logic e);
    if (r) begin
      m_owner = -1; m_rel = 0; m_wait = 0; m_tx = 0; m_last = N - 1;
    end else if (m_rel != 0) begin
      m_rel = 0;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        if (m_owner < 0 && req[(m_last + i) % N]) begin
          m_owner = (m_last + i) % N;
        end
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_wait = 0; m_tx = 0;
      end
    end else if (m_tx != 0) begin
      if (f || e) begin
        m_owner = -1; m_tx = 0; m_rel = 1;
      end
    end else begin
      if (e || (b && f) || (!b && (!req[m_owner] || m_wait == T - 1))) begin
        m_owner = -1; m_rel = 1;
      end else if (b) begin
        m_tx = 1;
      end else begin
        m_wait++;
      end
    end
  endtask

  initial begin
    int cycles;
    logic r, b, f, e;
    logic [3:0] req;

    // rst req beg fin err | granted id idle
    add(1, 4'b0000, 0, 0, 0, 4'b0000, 2'd3, 1);
    add(0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b0001, 1, 0, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b0001, 0, 1, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0001, 0, 0, 0, 4'b0000, 2'd0, 1);
    add(0, 4'b0100, 0, 0, 0, 4'b0100, 2'd2, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 2'd2, 0);
    add(0, 4'b0000, 0, 1, 0, 4'b0000, 2'd2, 1);
    add(0, 4'b0000, 0, 1, 0, 4'b0000, 2'd2, 1);
    add(0, 4'b0000, 1, 0, 1, 4'b0000, 2'd2, 1);
    add(0, 4'b0010, 0, 0, 0, 4'b0010, 2'd1, 0);
    add(0, 4'b0010, 1, 0, 0, 4'b0010, 2'd1, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0010, 2'd1, 0);
    add(0, 4'b0000, 0, 0, 1, 4'b0000, 2'd1, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 2'd1, 1);
    add(0, 4'b1000, 0, 0, 0, 4'b1000, 2'd3, 0);
    add(0, 4'b1000, 1, 0, 0, 4'b1000, 2'd3, 0);
    add(1, 4'b0110, 0, 0, 0, 4'b0000, 2'd3, 1);
    add(0, 4'b0110, 0, 0, 0, 4'b0010, 2'd1, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 2'd1, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 2'd1, 1);
    add(0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b0001, 1, 1, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1);
    add(0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b0001, 0, 0, 1, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].beg, vecs[i].fin, vecs[i].err);
      check($sformatf("vec%0d_granted", i), int'(bus.granted), int'(vecs[i].g));
      check($sformatf("vec%0d_active_id", i), int'(bus.active_id), int'(vecs[i].id));
      check($sformatf("vec%0d_bus_idle", i), int'(bus.bus_idle), int'(vecs[i].idle));
    end

    // Rotation with all masters requesting: 0,1,2,3,0.
    drive(1, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'b1111, 0, 0, 0);
      check($sformatf("rot%0d_grant", k), int'(bus.granted), 1 << (k % N));
      check($sformatf("rot%0d_id", k), int'(bus.active_id), k % N);
      drive(0, 4'b1111, 1, 0, 0);
      drive(0, 4'b1111, 0, 0, 0);
      drive(0, 4'b1111, 0, 0, 0);
      check($sformatf("rot%0d_held", k), int'(bus.granted), 1 << (k % N));
      drive(0, 4'b1111, 0, 1, 0);
      check($sformatf("rot%0d_release", k), int'(bus.granted), 0);
      drive(0, 4'b1111, 0, 0, 0);
      check($sformatf("rot%0d_idle_gap", k), int'(bus.bus_idle), 1);
      check($sformatf("rot%0d_idle_nogrant", k), int'(bus.granted), 0);
    end

    // Owner 2 never begins: grant revoked after GRANT_TIMEOUT cycles, then 3.
    drive(1, 4'b0000, 0, 0, 0);
    drive(0, 4'b0100, 0, 0, 0);
    check("to_grant2", int'(bus.granted), 4'b0100);
    cycles = 1;
    while (cycles < 40) begin
      drive(0, 4'b1100, 0, 0, 0);
      if (bus.granted == 4'b0100) cycles++;
      else break;
    end
    check("to_length", cycles, T);
    check("to_release_grant", int'(bus.granted), 0);
    check("to_release_busy", int'(bus.bus_idle), 0);
    drive(0, 4'b1100, 0, 0, 0);
    check("to_idle", int'(bus.bus_idle), 1);
    drive(0, 4'b1100, 0, 0, 0);
    check("to_next_grant3", int'(bus.granted), 4'b1000);
    check("to_next_id3", int'(bus.active_id), 3);

    // Random traffic against the reference model.
    drive(1, 4'b0000, 0, 0, 0);
    model_step(1, 4'b0000, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(63) == 0);
      req = 4'($urandom_range(15));
      b   = ($urandom_range(3) == 0);
      f   = ($urandom_range(4) == 0);
      e   = ($urandom_range(19) == 0);
      model_step(r, req, b, f, e);
      drive(r, req, b, f, e);
      check($sformatf("rnd%0d_granted", c), int'(bus.granted),
            (m_owner >= 0) ? (1 << m_owner) : 0);
      check($sformatf("rnd%0d_active_id", c), int'(bus.active_id), m_last);
      check($sformatf("rnd%0d_bus_idle", c), int'(bus.bus_idle),
            (m_owner < 0 && m_rel == 0) ? 1 : 0);
      check($sformatf("rnd%0d_onehot", c), ($countones(bus.granted) > 1) ? 1 : 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of bus masters (2..8).
REQ-002 SHALL provide parameter GRANT_TIMEOUT, default 16, the maximum number of cycles between a grant and begin_transaction.
REQ-003 SHALL provide port system_clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL provide port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL provide port request, input, NUM_REQ, one request line per master; bit 0 is the JTAG bridge.
REQ-006 SHALL provide port granted, output, NUM_REQ, one-hot or zero bus grant per master.
REQ-007 SHALL provide port begin_transaction, input, 1, monitored shared-bus begin strobe.
REQ-008 SHALL provide port end_transaction, input, 1, monitored shared-bus end strobe.
REQ-009 SHALL provide port error, input, 1, monitored shared-bus error.
REQ-010 SHALL provide port active_id, output, clog2(NUM_REQ), index of the current or last owner.
REQ-011 SHALL provide port bus_idle, output, 1, high only in state IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, BUSY and RELEASE.
REQ-013 IDLE: when any request bit is set, SHALL select the winner round-robin, starting at (last owner+1) mod NUM_REQ.
- Selection goes to GRANT.
- granted is registered and asserted on the next edge (1-cycle latency).
REQ-014 GRANT: begin_transaction SHALL move the FSM to BUSY with granted held.
REQ-015 GRANT: if the owner's request drops before begin_transaction, the FSM SHALL go to RELEASE.
REQ-016 GRANT: a timeout counter SHALL count cycles in GRANT.
- It reaches GRANT_TIMEOUT-1 without begin_transaction: go to RELEASE (grant revoked).
REQ-017 BUSY: end_transaction or error SHALL move the FSM to RELEASE.
- granted is deasserted on the same edge.
- Request level is ignored in BUSY.
REQ-018 RELEASE SHALL last exactly one cycle with granted=0, then return to IDLE.
- Minimum gap between grants is 2 cycles (RELEASE, IDLE evaluation).
REQ-019 Grant stability: at most one granted bit SHALL be set.
- granted never changes owner without passing through RELEASE.
REQ-020 active_id SHALL update when a winner is selected and hold until the next selection.
- This value is the round-robin pointer.
REQ-021 Simultaneous begin_transaction and end_transaction in GRANT SHALL be treated as a 1-cycle transaction and go to RELEASE.
REQ-022 begin_transaction, end_transaction and error SHALL be ignored in IDLE and RELEASE.
REQ-023 An error in GRANT SHALL go to RELEASE.
REQ-024 The timeout counter SHALL be width clog2(GRANT_TIMEOUT)+1, saturating, and cleared on entry to GRANT.

Reset
REQ-025 reset SHALL force the following on the next edge, regardless of state (including mid-transaction):
- state=IDLE, granted=0, active_id=NUM_REQ-1 (so master 0 wins first), bus_idle=1, timeout counter=0.

Structure
REQ-026 Package bus_arbiter_pkg SHALL hold the state encoding (2-bit), the default NUM_REQ and the default GRANT_TIMEOUT.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_priority_select.
- Inputs: request vector, pointer.
- Outputs: valid and winner index.
REQ-028 RTL SHALL hold the FSM, timeout counter and grant register in bus_arbiter.

Verification
REQ-029 Reset, request=4'b0001: granted=4'b0001 one cycle later; begin at +2, end at +5 -> granted=0 at +6, bus_idle=1 at +7.
REQ-030 request=4'b1111 held: grants SHALL rotate 0,1,2,3,0, each with a 3-cycle transaction and a 1-cycle RELEASE gap between grants.
REQ-031 Owner 2 is granted and never begins: with GRANT_TIMEOUT=16, granted drops after 16 cycles in GRANT; the next grant goes to 3 if it is requesting.
REQ-032 error asserted in BUSY for owner 1: granted=0 on the next cycle, and active_id stays 1 until the next selection.
REQ-033 reset asserted in BUSY: granted=0 and state=IDLE next cycle; with request=4'b0110, the next grant goes to 1.
REQ-034 Owner drops request in GRANT before begin: RELEASE, then IDLE; end_transaction pulsed in IDLE causes no state change.
